// File: rtl/game_button_conditioner.sv
// Pad-level button front end: per-channel synchroniser, debouncer and
// press/release/held/auto-repeat event generator.
module game_button_conditioner #(
  parameter int unsigned N_BTN         = 3,
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned REPEAT_DELAY  = 1000,
  parameter int unsigned REPEAT_CYCLES = 500
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] held_o,
  output logic [N_BTN-1:0] rpt_o,
  output logic             any_press_o
);

  localparam int unsigned CNT_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned RCNT_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int unsigned RCNT_W   = $clog2(RCNT_MAX + 1);

  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_SAT  = RCNT_W'(RCNT_MAX);
  localparam logic [RCNT_W-1:0] RPT_FIRST = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RPT_NEXT  = RCNT_W'(REPEAT_CYCLES);
  localparam bit                RPT_EN    = (REPEAT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_d;
  logic [N_BTN-1:0] held_d;
  logic [N_BTN-1:0] rpt_d;

  // Two-flop synchroniser; runs regardless of enable
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_i;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d, rcnt_inc;
    logic               rep_q, rep_d;
    logic               s;
    logic               rpt_hit;

    assign s        = sync_q2[i];
    assign rcnt_inc = (rcnt_q == RCNT_SAT) ? rcnt_q : rcnt_q + RCNT_W'(1);
    // First repeat after REPEAT_DELAY held cycles, then every REPEAT_CYCLES
    assign rpt_hit  = RPT_EN && (rcnt_inc == (rep_q ? RPT_NEXT : RPT_FIRST));

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        rcnt_q  <= '0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rcnt_q  <= rcnt_d;
        rep_q   <= rep_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      rep_d   = rep_q;
      if (!en) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rcnt_d  = '0;
        rep_d   = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (s) begin
              state_d = ST_PRESS_CHK;
              cnt_d   = CNT_W'(1);
            end
          end
          ST_PRESS_CHK: begin
            if (!s) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
              state_d = ST_PRESSED;
              cnt_d   = '0;
              rcnt_d  = '0;
              rep_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          ST_PRESSED: begin
            if (!s) begin
              state_d = ST_RELEASE_CHK;
              cnt_d   = CNT_W'(1);
            end else if (rpt_hit) begin
              rcnt_d = '0;
              rep_d  = 1'b1;
            end else begin
              rcnt_d = rcnt_inc;
            end
          end
          ST_RELEASE_CHK: begin
            // Repeat timing is frozen here and resumes if the release is rejected
            if (s) begin
              state_d = ST_PRESSED;
              cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              rcnt_d  = '0;
              rep_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_comb begin
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
      rpt_d[i]     = 1'b0;
      held_d[i]    = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_CHK);
      if (en) begin
        press_d[i]   = (state_q == ST_PRESS_CHK) && s && (cnt_q == DB_LAST);
        release_d[i] = (state_q == ST_RELEASE_CHK) && !s && (cnt_q == DB_LAST);
        rpt_d[i]     = (state_q == ST_PRESSED) && s && rpt_hit;
      end
    end
  end

  // Registered event outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      press_o     <= '0;
      release_o   <= '0;
      held_o      <= '0;
      rpt_o       <= '0;
      any_press_o <= 1'b0;
    end else begin
      press_o     <= press_d;
      release_o   <= release_d;
      held_o      <= held_d;
      rpt_o       <= rpt_d;
      any_press_o <= |press_d;
    end
  end

endmodule
